// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one partial product per clock, start/done handshake.
// Define SEQ_MULT_SIGNED_EN to add a signed_mode port for two's-complement operands.
module seq_multiplier #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               signed_mode,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_next;
    logic [2*WIDTH-1:0] mcand, acc, addend, acc_sum;
    logic [WIDTH-1:0]   mplier, a_mag, b_mag;
    logic [CNT_W-1:0]   cnt;
    logic               neg, neg_in;
    logic               accept, last;

    assign accept = (state == IDLE) && start;
    assign last   = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
    assign busy   = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Signed operands run through the unsigned loop as magnitudes; sign is restored at completion.
`ifdef SEQ_MULT_SIGNED_EN
    always_comb begin
        a_mag  = (signed_mode && A[WIDTH-1]) ? (~A + 1'b1) : A;
        b_mag  = (signed_mode && B[WIDTH-1]) ? (~B + 1'b1) : B;
        neg_in = signed_mode && (A[WIDTH-1] ^ B[WIDTH-1]);
    end
`else
    always_comb begin
        a_mag  = A;
        b_mag  = B;
        neg_in = 1'b0;
    end
`endif

    assign addend  = mplier[0] ? mcand : '0;
    assign acc_sum = acc + addend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            P      <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                mcand  <= {{WIDTH{1'b0}}, a_mag};
                mplier <= b_mag;
                acc    <= '0;
                cnt    <= '0;
                neg    <= neg_in;
            end else if (state == RUN) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                // Final add and optional negation land on the same edge, so latency stays WIDTH.
                if (last) begin
                    P    <= neg ? (~acc_sum + 1'b1) : acc_sum;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: WIDTH=3 and WIDTH=8 instances, plus WIDTH=4 signed
// instance when SEQ_MULT_SIGNED_EN is defined.
module tb_seq_multiplier;

    logic clk;
    logic rst_n;

    logic       s3, busy3, done3;
    logic [2:0] a3, b3;
    logic [5:0] p3;

    logic        s8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_multiplier #(.WIDTH(3)) u_m3 (
        .clk(clk), .rst_n(rst_n), .start(s3), .A(a3), .B(b3),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode(1'b0),
`endif
        .busy(busy3), .done(done3), .P(p3)
    );

    seq_multiplier #(.WIDTH(8)) u_m8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .A(a8), .B(b8),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode(1'b0),
`endif
        .busy(busy8), .done(done8), .P(p8)
    );

`ifdef SEQ_MULT_SIGNED_EN
    logic       s4, m4, busy4, done4;
    logic [3:0] a4, b4;
    logic [7:0] p4;

    seq_multiplier #(.WIDTH(4)) u_m4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .A(a4), .B(b4), .signed_mode(m4),
        .busy(busy4), .done(done4), .P(p4)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset;
        int pulses;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy3 !== 1'b0 || done3 !== 1'b0 || p3 !== 6'd0 || busy8 !== 1'b0 || p8 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy3=%b done3=%b p3=%0d busy8=%b p8=%0d, required all 0", busy3, done3, p3, busy8, p8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Abort mid-run: 5*7 accepted, then reset between edges
        @(negedge clk);
        a3 = 3'd5; b3 = 3'd7; s3 = 1'b1;
        @(negedge clk);
        s3 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy3 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_busy: busy=%b, required 1", busy3);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy3 !== 1'b0 || done3 !== 1'b0 || p3 !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_midrun: busy=%b done=%b P=%0d, required 0/0/0", busy3, done3, p3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done3 === 1'b1 || busy3 !== 1'b0) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL reset_no_done: %0d cycles with done/busy active, required 0", pulses);
        end
    endtask

    task automatic test_exhaustive;
        logic [5:0] exp;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                exp = 6'(a * b);
                a3 = 3'(a); b3 = 3'(b); s3 = 1'b1;
                @(negedge clk);
                s3 = 1'b0;
                for (int i = 1; i <= 3; i++) begin
                    @(negedge clk);
                    if (i < 3) begin
                        n_cmp++;
                        if (done3 !== 1'b0 || busy3 !== 1'b1) begin
                            n_fail++;
                            $display("FAIL exh_run %0d*%0d cyc%0d: done=%b busy=%b, required 0/1", a, b, i, done3, busy3);
                        end
                    end else begin
                        n_cmp++;
                        if (done3 !== 1'b1 || p3 !== exp || busy3 !== 1'b0) begin
                            n_fail++;
                            $display("FAIL exh_done %0d*%0d: done=%b busy=%b P=%0d, required 1/0/%0d", a, b, done3, busy3, p3, exp);
                        end
                    end
                end
                @(negedge clk);
                n_cmp++;
                if (done3 !== 1'b0 || p3 !== exp) begin
                    n_fail++;
                    $display("FAIL exh_pulse %0d*%0d: done=%b P=%0d, required 0/%0d", a, b, done3, p3, exp);
                end
            end
        end
    endtask

    task automatic test_latency_ignore;
        int pulses;
        pulses = 0;
        a8 = 8'd255; b8 = 8'd255; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) pulses++;
            if (i == 8) begin
                n_cmp++;
                if (done8 !== 1'b1 || p8 !== 16'd65025 || busy8 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lat_done: done=%b busy=%b P=%0d, required 1/0/65025", done8, busy8, p8);
                end
            end
            if (i == 2) begin s8 = 1'b1; a8 = 8'd1; b8 = 8'd1; end
            if (i == 3) s8 = 1'b0;
        end
        n_cmp++;
        if (pulses !== 1 || p8 !== 16'd65025) begin
            n_fail++;
            $display("FAIL lat_ignore: pulses=%0d P=%0d, required 1/65025", pulses, p8);
        end
    endtask

    task automatic test_back_to_back;
        int d1, d2, bad_hold;
        d1 = 0; d2 = 0; bad_hold = 0;
        a8 = 8'd12; b8 = 8'd10; s8 = 1'b1;
        @(negedge clk);
        a8 = 8'd3; b8 = 8'd4;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                if (d1 == 0) d1 = i; else if (d2 == 0) d2 = i;
            end
            if (i == 8) begin
                n_cmp++;
                if (p8 !== 16'd120) begin
                    n_fail++;
                    $display("FAIL b2b_first: P=%0d, required 120", p8);
                end
            end
            if (i > 8 && i < 17 && p8 !== 16'd120) bad_hold++;
            if (i == 17) begin
                n_cmp++;
                if (p8 !== 16'd12) begin
                    n_fail++;
                    $display("FAIL b2b_second: P=%0d, required 12", p8);
                end
            end
            if (i == 9) s8 = 1'b0;
        end
        n_cmp++;
        if (d1 !== 8 || d2 !== 17) begin
            n_fail++;
            $display("FAIL b2b_spacing: done at cycles %0d,%0d, required 8,17", d1, d2);
        end
        n_cmp++;
        if (bad_hold !== 0) begin
            n_fail++;
            $display("FAIL b2b_hold: P changed in %0d cycles of second run, required 0", bad_hold);
        end
    endtask

    task automatic test_hold;
        int bad;
        bad = 0;
        a8 = 8'd12; b8 = 8'd10; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (p8 !== 16'd120 || done8 !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_setup: P=%0d done=%b, required 120/1", p8, done8);
        end
        for (int i = 0; i < 20; i++) begin
            a8 = ~a8 ^ 8'(i); b8 = b8 + 8'd37;
            @(negedge clk);
            if (p8 !== 16'd120 || done8 !== 1'b0 || busy8 !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL hold_stable: %0d bad cycles, required 0 (P=%0d)", bad, p8);
        end
    endtask

`ifdef SEQ_MULT_SIGNED_EN
    task automatic test_signed;
        logic [3:0] va [4] = '{4'h8, 4'h8, 4'h5, 4'hF};
        logic [3:0] vb [4] = '{4'h8, 4'h7, 4'hD, 4'hF};
        logic       vm [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] ve [4] = '{8'd64, 8'hC8, 8'hF1, 8'd225};
        for (int k = 0; k < 4; k++) begin
            a4 = va[k]; b4 = vb[k]; m4 = vm[k]; s4 = 1'b1;
            @(negedge clk);
            s4 = 1'b0; m4 = ~m4;
            repeat (4) @(negedge clk);
            n_cmp++;
            if (done4 !== 1'b1 || p4 !== ve[k]) begin
                n_fail++;
                $display("FAIL signed_%0d: done=%b P=%h, required 1/%h", k, done4, p4, ve[k]);
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        s3 = 1'b0; a3 = '0; b3 = '0;
        s8 = 1'b0; a8 = '0; b8 = '0;
`ifdef SEQ_MULT_SIGNED_EN
        s4 = 1'b0; a4 = '0; b4 = '0; m4 = 1'b0;
`endif
        test_reset;
        @(negedge clk);
        test_exhaustive;
        @(negedge clk);
        test_latency_ignore;
        @(negedge clk);
        test_back_to_back;
        @(negedge clk);
        test_hold;
`ifdef SEQ_MULT_SIGNED_EN
        @(negedge clk);
        test_signed;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised sequential shift-add multiplier; successor to the 3-bit combinational multiplier.
- Trades latency for area: one partial product per clock.
- Sits behind a start/done handshake so datapath controllers can issue multiplies and poll or wait for completion.
- Product stays registered and stable until the next operation completes.

Parameters:
- WIDTH, 8, operand width in bits (legal 2..32); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when not busy.
- A  input  WIDTH  multiplicand; latched when start is accepted.
- B  input  WIDTH  multiplier; latched when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when P is updated.
- P  output  2*WIDTH  registered product.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, P=0, internal accumulator/operand/counter regs=0.
- States:
  - IDLE: start=1 at edge k -> latch A into mcand (zero-extended to 2*WIDTH), latch B into mplier, acc=0, cnt=0, go to RUN; busy=1 after edge k.
  - RUN, one iteration per edge:
    - if mplier[0], acc += mcand;
    - mcand <<= 1, mplier >>= 1, cnt++.
  - Completion: on the edge where cnt reaches WIDTH (edge k+WIDTH), P <= final acc, done=1 for exactly one cycle, busy=0, state=IDLE.
- Latency: start accepted at edge k -> P valid and done high after edge k+WIDTH. Throughput: one result per WIDTH+1 cycles with back-to-back starts.
- No early termination; latency is fixed regardless of operand values, including zeros.
- Arithmetic: unsigned. All adds are 2*WIDTH bits wide and cannot overflow, since max product (2^W-1)^2 < 2^(2W).
- start while busy=1: ignored, no queuing; operands are not re-sampled.
- start high in the cycle done=1 (state IDLE): accepted; the new operation begins. P holds the previous result until the new completion.
- A/B changing during RUN: no effect.
- P and done change only at completion. P is never updated with partial sums.
- Reset mid-operation: aborts immediately; P=0, no done pulse.
- start held high continuously: operations chain back-to-back, each with a new A/B sample at its accept edge.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN.
- Defined: adds input port `signed_mode` (1 bit), sampled with A/B at accept.
  - signed_mode=1: A and B are two's complement.
  - Implementation: latch magnitudes, run the unsigned loop, then negate the result on completion if sign(A) XOR sign(B).
  - Latency is unchanged: the negation is folded into the completion edge.
  - Example, WIDTH=3: A=3'b111 (-1), B=3'b011 (3) -> P=6'b111101 (-3).
  - signed_mode=0: identical to unsigned.
- Not defined: no signed_mode port; unsigned only.

Test Plan:
- Reset: rst_n=0 asserted mid-RUN with A=5, B=7 (WIDTH=3) -> busy=0, done=0, P=0 immediately, without a clock edge; no done pulse follows.
- Exhaustive, WIDTH=3: all 64 A/B pairs, one start each, wait for done -> P=A*B (e.g. 7*7=49, 0*5=0); done high exactly 1 cycle, arriving 3 edges after accept.
- Latency and ignore rule, WIDTH=8:
  - A=255, B=255, start at edge k -> done after edge k+8, P=65025.
  - A second start pulse at k+3 with A=1, B=1 is ignored: P=65025, only one done pulse.
- Back-to-back, WIDTH=8: start held high with A=12/B=10 then A=3/B=4 -> done pulses 9 cycles apart; P=120, then P=12. P stays 120 during the second RUN.
- Hold/stability: after P=120 completes, toggle A/B with start=0 for 20 cycles -> P stays 120, done stays 0, busy stays 0.
- Signed (SEQ_MULT_SIGNED_EN, WIDTH=4, signed_mode=1):
  - -8*-8 -> P=64.
  - -8*7 -> P=8'hC8.
  - 5*-3 -> P=8'hF1.
  - signed_mode=0 with 4'hF*4'hF -> P=225.
